// File: rtl/fpdiv_sp_stream_adapter.sv
// fpdiv_sp_stream_adapter: valid/ready front end for a fixed-latency FloPoCo
// single-precision divider. Operands go straight into the divider. A valid
// shift register marks which divider outputs are real results, and those are
// captured into a small FIFO. The adapter only accepts an operand pair when
// the FIFO is guaranteed to have room for its result. Because of this, the
// divider never needs to be stalled.
module fpdiv_sp_stream_adapter #(
  parameter int NUM_STAGES = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [33:0]                      in_a,
  input  logic [33:0]                      in_b,
  output logic                             div_ce,
  output logic [33:0]                      div_x,
  output logic [33:0]                      div_y,
  input  logic [33:0]                      div_r,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [33:0]                      out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

  logic [NUM_STAGES-1:0] vld_pipe;
  logic [33:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt, inflight_q;
  logic [CW:0]           used;
  logic                  accept, capture, pop, full;

  // The divider free-runs so results always drain; operands go in unregistered.
  assign div_ce = 1'b1;
  assign div_x  = in_a;
  assign div_y  = in_b;

  // A slot is committed from accept until pop. Credit is taken only from
  // registered counts, so a freed slot is usable one cycle after it is freed.
  assign used      = {1'b0, fifo_cnt} + {1'b0, inflight_q};
  assign in_ready  = (used < DEPTH_W) & ~rst;
  assign accept    = in_valid & in_ready;
  assign capture   = vld_pipe[NUM_STAGES-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];
  assign full      = (fifo_cnt == FULL_CNT);
  assign inflight  = inflight_q;

  // Mark each divider stage that holds a real operation. The last bit lines up with div_r.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < NUM_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Count operations issued to the divider whose results have not yet been captured.
  always_ff @(posedge clk) begin
    if (rst)                   inflight_q <= '0;
    else if (accept & ~capture) inflight_q <= inflight_q + 1'b1;
    else if (~accept & capture) inflight_q <= inflight_q - 1'b1;
  end

  // Result storage. The head is read combinationally, which gives first-word fall-through.
  always_ff @(posedge clk) begin
    if (capture & ~rst) mem[wr_ptr] <= div_r;
  end

  // FIFO pointers wrap at FIFO_DEPTH-1, so any depth works (not only powers of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (capture) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (capture & ~pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (~capture & pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // The credit scheme makes capture into a full FIFO (with no pop in the same cycle) impossible.
  assert property (@(posedge clk) disable iff (rst) !(capture && full && !pop));

endmodule
